spi_xfer_seq: RTL

SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

---
 rtl/spi_xfer_seq_if.sv | 27 ++
 rtl/spi_xfer_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/spi_xfer_seq_if.sv
// spi_xfer_seq_if: host FIFO, transaction control and byte-engine signals of spi_xfer_seq
interface spi_xfer_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] xfer_len;
  logic       go;
  logic       active;
  logic       done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       eng_start;
  logic [7:0] eng_data;
  logic       eng_busy;
  logic       eng_new_data;
  logic [7:0] eng_data_out;
  logic       cs_n;
  modport slave (
    input  tx_data, tx_valid, xfer_len, go, rx_ready, eng_busy, eng_new_data, eng_data_out,
    output tx_ready, active, done, rx_data, rx_valid, eng_start, eng_data, cs_n
  );
  modport master (
    output tx_data, tx_valid, xfer_len, go, rx_ready, eng_busy, eng_new_data, eng_data_out,
    input  tx_ready, active, done, rx_data, rx_valid, eng_start, eng_data, cs_n
  );
endinterface

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: chip-select sequencer feeding a one-byte SPI engine from a TX FIFO into an RX FIFO
module spi_xfer_seq #(
  parameter int DEPTH    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input logic           clk,
  input logic           rst,
  spi_xfer_seq_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [AW:0]   FULL       = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, HOLD} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    rem_q, rem_d;
  logic          cs_n_q, cs_n_d;
  logic          eng_start_q, eng_start_d;
  logic          done_q, done_d;
  logic [7:0]    eng_data_q, eng_data_d;
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    tx_mem_d [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    rx_mem_d [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_push, tx_pop, rx_push, rx_pop, issue;
  // RX space is reserved at issue time so the WAIT push can never overflow
  assign issue   = (state_q == ISSUE) && (tx_cnt_q != '0) && (rx_cnt_q != FULL) && !bus.eng_busy;
  assign tx_push = bus.tx_valid && (tx_cnt_q != FULL);
  assign tx_pop  = issue;
  assign rx_push = (state_q == WAIT) && bus.eng_new_data;
  assign rx_pop  = bus.rx_ready && (rx_cnt_q != '0);
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push) tx_mem_d[tx_wr_q] = bus.tx_data;
    if (rx_push) rx_mem_d[rx_wr_q] = bus.eng_data_out;
    tx_wr_d  = tx_wr_q + AW'(tx_push);
    tx_rd_d  = tx_rd_q + AW'(tx_pop);
    rx_wr_d  = rx_wr_q + AW'(rx_push);
    rx_rd_d  = rx_rd_q + AW'(rx_pop);
    tx_cnt_d = tx_cnt_q + (AW + 1)'(tx_push) - (AW + 1)'(tx_pop);
    rx_cnt_d = rx_cnt_q + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    eng_start_d = 1'b0;
    eng_data_d  = eng_data_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (bus.go) begin
        if (bus.xfer_len != 8'd0) begin
          state_d = SETUP;
          rem_d   = bus.xfer_len;
          cnt_d   = '0;
        end else done_d = 1'b1;
      end
      SETUP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == SETUP_LAST) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: if (issue) begin
        eng_start_d = 1'b1;
        eng_data_d  = tx_mem_q[tx_rd_q];
        state_d     = WAIT;
      end
      WAIT: if (bus.eng_new_data) begin
        rem_d   = rem_q - 8'd1;
        state_d = (rem_q == 8'd1) ? HOLD : ISSUE;
        cnt_d   = '0;
      end
      HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    cs_n_d = (state_d == IDLE);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      cs_n_q      <= 1'b1;
      eng_start_q <= 1'b0;
      eng_data_q  <= '0;
      done_q      <= 1'b0;
      tx_mem_q    <= '{default: '0};
      rx_mem_q    <= '{default: '0};
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      cs_n_q      <= cs_n_d;
      eng_start_q <= eng_start_d;
      eng_data_q  <= eng_data_d;
      done_q      <= done_d;
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end
  assign bus.tx_ready  = tx_cnt_q != FULL;
  assign bus.rx_valid  = rx_cnt_q != '0;
  assign bus.rx_data   = rx_mem_q[rx_rd_q];
  assign bus.active    = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_data  = eng_data_q;
  assign bus.cs_n      = cs_n_q;
endmodule
